// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI mode-0 register-file responder.
package spi_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RD,
    WR,
    IGNORE,
    ID
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_ID    = 8'h9F;
  localparam int         SYNC_STAGES = 2;

endpackage

// File: rtl/spi_responder_sync.sv
// Synchronizes {mosi, sclk, ss} into the system clock domain and produces
// registered edge pulses plus levels aligned with those pulses.
module spi_responder_sync
  import spi_responder_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ss,
  input  logic sclk,
  input  logic mosi,
  output logic ss_q,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_q,
  output logic ss_rise
);

  // Bit order {mosi, sclk, ss}; the bus idles with SS high.
  localparam logic [2:0] IDLE_LEVEL = 3'b001;

  logic [2:0] stage_reg [SYNC_STAGES];
  logic [2:0] prev_reg;
  logic       sclk_rise_reg;
  logic       sclk_fall_reg;
  logic       ss_rise_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_reg[i] <= IDLE_LEVEL;
      prev_reg      <= IDLE_LEVEL;
      sclk_rise_reg <= 1'b0;
      sclk_fall_reg <= 1'b0;
      ss_rise_reg   <= 1'b0;
    end else begin
      stage_reg[0] <= {mosi, sclk, ss};
      for (int i = 1; i < SYNC_STAGES; i++) stage_reg[i] <= stage_reg[i-1];
      prev_reg      <= stage_reg[SYNC_STAGES-1];
      sclk_rise_reg <= stage_reg[SYNC_STAGES-1][1] & ~prev_reg[1];
      sclk_fall_reg <= ~stage_reg[SYNC_STAGES-1][1] & prev_reg[1];
      ss_rise_reg   <= stage_reg[SYNC_STAGES-1][0] & ~prev_reg[0];
    end
  end

  // prev_reg is updated on the same edge as the pulses, so its levels line up with them.
  assign ss_q      = prev_reg[0];
  assign mosi_q    = prev_reg[2];
  assign sclk_rise = sclk_rise_reg;
  assign sclk_fall = sclk_fall_reg;
  assign ss_rise   = ss_rise_reg;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 target with a byte-addressed register file, read/write commands
// and a write strobe. Define SPI_RESPONDER_ID_EN to enable the 0x9F ID command.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [7:0]  ID_BYTE = 8'hA5,
  localparam int         AW      = $clog2(DEPTH)
) (
  input  logic          io_clock,
  input  logic          io_reset,
  input  logic          io_spi_ss,
  input  logic          io_spi_sclk,
  input  logic          io_spi_mosi,
  output logic          io_spi_miso,
  output logic          busy,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

`ifdef SPI_RESPONDER_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic ss_q, sclk_rise, sclk_fall, mosi_q, ss_rise;

  spi_responder_sync u_sync (
    .clk       (io_clock),
    .rst_n     (io_reset),
    .ss        (io_spi_ss),
    .sclk      (io_spi_sclk),
    .mosi      (io_spi_mosi),
    .ss_q      (ss_q),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_q    (mosi_q),
    .ss_rise   (ss_rise)
  );

  state_t          state_reg, state_next;
  logic [2:0]      bit_cnt_reg;
  logic [6:0]      rx_shift_reg;
  logic [7:0]      tx_shift_reg;
  logic [AW-1:0]   addr_reg;
  logic            is_read_reg;
  logic            miso_reg;
  logic            wr_valid_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic [7:0]      wr_data_reg;
  logic [7:0]      mem_reg [DEPTH];

  logic [7:0]      rx_byte;
  logic            byte_done;
  logic [AW-1:0]   addr_inc;

  // SS rise takes priority over any SCLK edge seen in the same cycle.
  assign rx_byte   = {rx_shift_reg, mosi_q};
  assign byte_done = sclk_rise && !ss_rise && (state_reg != IDLE) && (bit_cnt_reg == 3'd7);
  assign addr_inc  = addr_reg + AW'(1);

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (ss_rise) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (!ss_q) state_next = CMD;
        CMD: if (byte_done) begin
          if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) state_next = ADDR;
          else if (ID_EN && rx_byte == CMD_ID)              state_next = ID;
          else                                              state_next = IGNORE;
        end
        ADDR: if (byte_done) state_next = is_read_reg ? RD : WR;
        default: ;
      endcase
    end
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      tx_shift_reg <= '0;
      addr_reg     <= '0;
      is_read_reg  <= 1'b0;
      miso_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      wr_valid_reg <= 1'b0;
      if (ss_rise || state_reg == IDLE) begin
        bit_cnt_reg <= '0;
        miso_reg    <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift_reg <= rx_byte[6:0];
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        end
        if (sclk_fall && (state_reg == RD || state_reg == ID)) begin
          miso_reg     <= tx_shift_reg[7];
          tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
        end
        if (byte_done) begin
          case (state_reg)
            CMD: begin
              is_read_reg  <= (rx_byte == CMD_READ);
              tx_shift_reg <= ID_BYTE;
            end
            ADDR: begin
              addr_reg     <= rx_byte[AW-1:0];
              tx_shift_reg <= mem_reg[rx_byte[AW-1:0]];
            end
            RD: begin
              addr_reg     <= addr_inc;
              tx_shift_reg <= mem_reg[addr_inc];
            end
            WR: begin
              mem_reg[addr_reg] <= rx_byte;
              wr_valid_reg      <= 1'b1;
              wr_addr_reg       <= addr_reg;
              wr_data_reg       <= rx_byte;
              addr_reg          <= addr_inc;
            end
            ID: tx_shift_reg <= ID_BYTE;
            default: ;
          endcase
        end
      end
    end
  end

  assign io_spi_miso = miso_reg;
  assign busy        = ~ss_q;
  assign wr_valid    = wr_valid_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;

endmodule

// File: doc/spi_responder.md
# spi_responder

Synthesizable SPI mode-0 target that answers the SoC's SPI master (`io_spi0_*`) with a small byte-addressed register file. It sits outside the SoC top next to the device under test and is clocked from the system clock. It oversamples SCLK, SS and MOSI, decodes a read/write command protocol and reports every write on a strobe port for the bench scoreboard.

## Interface
- `DEPTH`, 16: number of byte registers; power of two, 2..256; `AW = $clog2(DEPTH)`.
- `ID_BYTE`, 8'hA5: byte returned by the ID command (see Configuration).
- `io_clock`  in  1  system clock; all logic is on the rising edge.
- `io_reset`  in  1  asynchronous, active-low reset.
- `io_spi_ss`  in  1  chip select, active low, asynchronous to `io_clock`.
- `io_spi_sclk`  in  1  SPI clock, CPOL=0, asynchronous.
- `io_spi_mosi`  in  1  master-out data, asynchronous.
- `io_spi_miso`  out  1  target-out data.
- `busy`  out  1  high while synchronized SS is low.
- `wr_valid`  out  1  one-cycle pulse per completed write byte.
- `wr_addr`  out  AW  address of the written byte; valid with `wr_valid`.
- `wr_data`  out  8  value of the written byte; valid with `wr_valid`.

## Operation
- Reset values: `io_spi_miso`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, all registers=8'h00, state=IDLE, bit counter=0.
- SS, SCLK and MOSI each pass through a 2-FF synchronizer, then an edge detector (rise/fall pulses).
- MOSI is sampled on the SCLK rise into an 8-bit shift register, MSB first. Bit counter 0..7; the 8th rise completes a byte.
- States:
  - IDLE: waits for SS falling, then → CMD.
  - CMD: byte 0x03 → ADDR (read); 0x02 → ADDR (write); any other byte → IGNORE.
  - ADDR: the low AW bits of the byte become the address. A read loads `tx_shift <= mem[addr]` and goes to RD. A write goes to WR.
  - RD: each SCLK fall drives `io_spi_miso <= tx_shift[7]` and shifts `tx_shift` left. Each completed byte increments addr and loads `mem[addr+1]`.
  - WR: each completed byte writes `mem[addr] <= byte`, pulses `wr_valid` with `wr_addr`=addr and `wr_data`=byte, then increments addr.
  - IGNORE: holds `io_spi_miso`=0 until SS rises.
- Address arithmetic wraps modulo DEPTH: addr DEPTH-1 → 0.
- SS rising in any state → IDLE next cycle. The bit counter clears, a partial byte is discarded (no write), and `io_spi_miso`=0.
- `io_spi_miso` is 0 in IDLE, CMD, ADDR and IGNORE.
- Simultaneous synchronized SS rise and SCLK edge: SS wins; the edge is ignored.
- Reset asserted mid-transfer: every output and register returns to its reset value immediately; the transfer is lost.

## Timing
- Input-to-edge-pulse latency: 3 `io_clock` cycles after the pin edge.
- `io_spi_miso` updates 4 `io_clock` cycles after the SCLK pin fall.
- `wr_valid` rises 4 `io_clock` cycles after the 8th SCLK pin rise of a byte.
- Requirement: each SCLK half period ≥ 6 `io_clock` cycles. At 50 MHz that means SCLK ≤ 4.16 MHz.
- SS setup before the first SCLK rise ≥ 4 `io_clock` cycles.
- Back-to-back transfers need SS high ≥ 4 `io_clock` cycles.

## Configuration
- `SPI_RESPONDER_ID_EN` defined: command 0x9F in CMD → state ID. ID drives `ID_BYTE` MSB-first on every following byte until SS rises; no address byte is taken.
- Macro undefined: 0x9F is an unknown command → IGNORE, and `io_spi_miso` stays 0.

## Structure
- `spi_responder_pkg` holds:
  - the state enum (IDLE, CMD, ADDR, RD, WR, IGNORE, ID);
  - `CMD_READ`=8'h03, `CMD_WRITE`=8'h02, `CMD_ID`=8'h9F;
  - `SYNC_STAGES`=2.
- Sub-module `spi_responder_sync`: a 3-bit 2-FF synchronizer plus edge detector that outputs `ss_q`, `sclk_rise`, `sclk_fall`, `mosi_q` and `ss_rise`.

## Test plan
- Write 0x02,0x04,0xDE,0xAD → `wr_valid` pulses twice: (4,0xDE), (5,0xAD). Then read 0x03,0x04,xx,xx → MISO returns 0xDE,0xAD.
- Write 0x02,0x0F,0x11,0x22 with DEPTH=16 → writes at addr 15 then addr 0. A read from 0x0F returns 0x11,0x22.
- Unknown command 0x55 followed by 3 bytes → MISO constantly 0, no `wr_valid`, registers unchanged.
- Write 0x02,0x03,0x77, then 4 bits of 0xFF, then SS high → exactly one write (3,0x77). The next read of addr 4 returns 0x00.
- Reset (`io_reset`=0) asserted during the 2nd data byte of a read → `io_spi_miso`=0 and `busy`=0 within 1 cycle, all registers read 0x00 afterwards.
- With `SPI_RESPONDER_ID_EN` defined: 0x9F + 2 bytes → MISO 0xA5,0xA5. Without the macro: MISO 0x00,0x00.
